// File: rtl/friet_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// friet_sequencer_pkg
// Shared constants and types for the Friet permutation sequencer: state
// geometry (twelve 32-bit words), round count, FSM encoding and the widths of
// the word counter and round index.
// -----------------------------------------------------------------------------
package friet_sequencer_pkg;

  localparam int STATE_WORDS = 12;
  localparam int WORD_WIDTH  = 32;
  localparam int NUM_ROUNDS  = 24;

  localparam int WORD_CNT_W  = 4;
  localparam int ROUND_IDX_W = 5;

  // Word-counter compare points, pre-sized so compares stay width-exact.
  localparam logic [WORD_CNT_W-1:0] WORDS_FULL = WORD_CNT_W'(STATE_WORDS);
  localparam logic [WORD_CNT_W-1:0] LAST_WORD  = WORD_CNT_W'(STATE_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_CHECK,
    ST_UNLOAD
  } state_t;

endpackage

// File: rtl/friet_round_scheduler.sv
// -----------------------------------------------------------------------------
// friet_round_scheduler
// Counts round groups during RUN and produces the first-round index of the
// current group plus a flag marking the final group.
//
// Ports:
//   aclk, aresetn  clock, asynchronous active-low reset
//   clear          return the group counter to 0 (wins over advance)
//   advance        step to the next group (wraps to 0 after the last one)
//   round_index    round_cnt * COMBINATIONAL_ROUNDS
//   last_group     high while the counter sits on the final group
// -----------------------------------------------------------------------------
module friet_round_scheduler #(
  parameter int COMBINATIONAL_ROUNDS = 3,
  parameter int NUM_ROUNDS           = 24
) (
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       clear,
  input  logic       advance,
  output logic [4:0] round_index,
  output logic       last_group
);

  localparam int IDX_W  = friet_sequencer_pkg::ROUND_IDX_W;
  localparam int GROUPS = NUM_ROUNDS / COMBINATIONAL_ROUNDS;

  logic [IDX_W-1:0] round_cnt;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      round_cnt <= '0;
    end else if (clear) begin
      round_cnt <= '0;
    end else if (advance) begin
      round_cnt <= last_group ? '0 : round_cnt + 1'b1;
    end
  end

  assign last_group  = (round_cnt == IDX_W'(GROUPS - 1));
  assign round_index = IDX_W'(int'(round_cnt) * COMBINATIONAL_ROUNDS);

endmodule

// File: rtl/friet_permutation_sequencer.sv
// -----------------------------------------------------------------------------
// friet_permutation_sequencer
// Core-side controller for the protected Friet permutation datapath. Loads the
// 384-bit state as twelve 32-bit words, runs NUM_ROUNDS/COMBINATIONAL_ROUNDS
// round-group cycles, folds the datapath fault flags into a sticky register
// and unloads the result word by word.
//
// Ports:
//   aclk, aresetn            clock, asynchronous active-low reset
//   din/din_valid/din_ready  state load, least significant word first
//   start, abort             single-cycle requests (abort has priority)
//   dout/dout_valid/dout_ready  result unload, least significant word first
//   busy, done, start_error, fault_detected  status
//   dp_*                     datapath control and observation
//
// Build option: define FRIET_FAULT_ZEROIZE_EN to clear the datapath and force
// dout to zero for the whole unload whenever the run saw a fault.
// -----------------------------------------------------------------------------
module friet_permutation_sequencer #(
  parameter int COMBINATIONAL_ROUNDS = 3,
  parameter int NUM_ROUNDS           = friet_sequencer_pkg::NUM_ROUNDS
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        start,
  input  logic        abort,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        busy,
  output logic        done,
  output logic        start_error,
  output logic        fault_detected,
  output logic [31:0] dp_din,
  output logic        dp_load_word,
  input  logic [31:0] dp_dout,
  output logic        dp_shift_out,
  output logic        dp_round_en,
  output logic [4:0]  dp_round_index,
  input  logic        dp_fault,
  output logic        dp_clear
);

  import friet_sequencer_pkg::*;

  if (COMBINATIONAL_ROUNDS < 1 || COMBINATIONAL_ROUNDS > 24 ||
      (24 % COMBINATIONAL_ROUNDS) != 0 ||
      (NUM_ROUNDS % COMBINATIONAL_ROUNDS) != 0) begin : g_bad_cfg
    $error("COMBINATIONAL_ROUNDS must divide 24 and NUM_ROUNDS");
  end

  state_t                state_q, state_d;
  logic [WORD_CNT_W-1:0] word_cnt;
  logic                  fault_q;
  logic                  last_group;
  logic                  start_ok;
  logic                  sched_clear;

  // Accepted start: only from IDLE with a full state, and never alongside abort.
  assign start_ok    = (state_q == ST_IDLE) && start && (word_cnt == WORDS_FULL) && !abort;
  // Group counter sits at 0 outside RUN, so every run begins at round 0.
  assign sched_clear = abort || (state_q != ST_RUN);

  friet_round_scheduler #(
    .COMBINATIONAL_ROUNDS (COMBINATIONAL_ROUNDS),
    .NUM_ROUNDS           (NUM_ROUNDS)
  ) u_round_scheduler (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .clear       (sched_clear),
    .advance     (state_q == ST_RUN),
    .round_index (dp_round_index),
    .last_group  (last_group)
  );

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: clocked state uses non-blocking assignments so every register samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment up front keeps every path driven, so no latch
  // is inferred when a branch leaves state_d alone.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_ok)   state_d = ST_RUN;
      ST_RUN:    if (last_group) state_d = ST_CHECK;
      ST_CHECK:                  state_d = ST_UNLOAD;
      ST_UNLOAD: if (dp_shift_out && word_cnt == LAST_WORD) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    din_ready   = 1'b0;
    dout_valid  = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    dp_round_en = 1'b0;
    case (state_q)
      ST_IDLE:   din_ready = (word_cnt < WORDS_FULL);
      ST_RUN:    begin busy = 1'b1; dp_round_en = 1'b1; end
      ST_CHECK:  begin busy = 1'b1; done = 1'b1; end
      ST_UNLOAD: dout_valid = 1'b1;
      default:   ;
    endcase
    // Handshakes colliding with abort are dropped; abort restarts the load.
    dp_load_word = din_valid && din_ready && !abort;
    dp_shift_out = dout_valid && dout_ready && !abort;
    dp_din       = dp_load_word ? din : {WORD_WIDTH{1'b0}};
`ifdef FRIET_FAULT_ZEROIZE_EN
    // fault_detected was loaded on leaving CHECK, so it describes this run.
    dout         = (dout_valid && !fault_detected) ? dp_dout : {WORD_WIDTH{1'b0}};
`else
    dout         = dout_valid ? dp_dout : {WORD_WIDTH{1'b0}};
`endif
  end

  // ---------------------------------------------------------------------------
  // Word counter, fault tracking and registered pulses
  // ---------------------------------------------------------------------------
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      word_cnt       <= '0;
      fault_q        <= 1'b0;
      fault_detected <= 1'b0;
      start_error    <= 1'b0;
      dp_clear       <= 1'b0;
    end else begin
      start_error <= 1'b0;
      dp_clear    <= 1'b0;
      if (abort) begin
        // Fault history survives an abort; only the load progress is dropped.
        word_cnt <= '0;
        dp_clear <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (dp_load_word) word_cnt <= word_cnt + 1'b1;
            if (start_ok) begin
              fault_q        <= 1'b0;
              fault_detected <= 1'b0;
            end else if (start) begin
              start_error <= 1'b1;
            end
          end
          ST_RUN: begin
            fault_q <= fault_q | dp_fault;
`ifdef FRIET_FAULT_ZEROIZE_EN
            // Registered here so the clear lands in the CHECK cycle.
            if (last_group && (fault_q || dp_fault)) dp_clear <= 1'b1;
`endif
          end
          ST_CHECK: begin
            fault_detected <= fault_q;
            word_cnt       <= '0;
          end
          ST_UNLOAD: begin
            if (dp_shift_out) word_cnt <= (word_cnt == LAST_WORD) ? '0 : word_cnt + 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_friet_permutation_sequencer.sv
// -----------------------------------------------------------------------------
// tb_friet_permutation_sequencer
// Directed bench for friet_permutation_sequencer (default parameters). A small
// behavioural datapath shifts loaded words in at the top, rotates on
// dp_shift_out and zeroes on dp_clear, so unloaded words must match the loaded
// ones. Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_friet_permutation_sequencer;

`ifdef FRIET_FAULT_ZEROIZE_EN
  localparam bit ZEROIZE_EN = 1'b1;
`else
  localparam bit ZEROIZE_EN = 1'b0;
`endif

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy, done, start_error, fault_detected;
  logic [31:0] dp_din;
  logic        dp_load_word;
  logic [31:0] dp_dout;
  logic        dp_shift_out, dp_round_en;
  logic [4:0]  dp_round_index;
  logic        dp_fault = 1'b0;
  logic        dp_clear;

  int errors = 0;
  int checks = 0;
  logic [31:0] exp_words [12];
  logic [31:0] dp_state  [12];

  always #5 aclk = ~aclk;

  friet_permutation_sequencer dut (
    .aclk(aclk), .aresetn(aresetn),
    .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .start(start), .abort(abort),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .busy(busy), .done(done), .start_error(start_error), .fault_detected(fault_detected),
    .dp_din(dp_din), .dp_load_word(dp_load_word), .dp_dout(dp_dout),
    .dp_shift_out(dp_shift_out), .dp_round_en(dp_round_en), .dp_round_index(dp_round_index),
    .dp_fault(dp_fault), .dp_clear(dp_clear)
  );

  // Behavioural datapath: rounds are the identity here.
  assign dp_dout = dp_state[0];
  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < 12; i++) dp_state[i] <= '0;
    end else if (dp_clear) begin
      for (int i = 0; i < 12; i++) dp_state[i] <= '0;
    end else if (dp_load_word) begin
      for (int i = 0; i < 11; i++) dp_state[i] <= dp_state[i+1];
      dp_state[11] <= dp_din;
    end else if (dp_shift_out) begin
      for (int i = 0; i < 11; i++) dp_state[i] <= dp_state[i+1];
      dp_state[11] <= dp_state[0];
    end
  end

  function automatic logic [31:0] exp_dout(input int idx, input bit flt);
    return (ZEROIZE_EN && flt) ? 32'd0 : exp_words[idx];
  endfunction

  task automatic set_expected(input logic [31:0] first);
    for (int i = 0; i < 12; i++) exp_words[i] = first + 32'(i);
  endtask

  task automatic load_words(input int n, input logic [31:0] first);
    int bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge aclk);
      din = first + 32'(i);
      din_valid = 1'b1;
      #1;
      if (din_ready !== 1'b1 || dp_load_word !== 1'b1 || dp_din !== first + 32'(i)) bad++;
    end
    @(negedge aclk);
    din_valid = 1'b0;
    din = '0;
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL load: %0d of %0d words refused or miscopied, required 0", bad, n);
    end
  endtask

  // Start a run; fault_cycle selects the RUN cycle (1-based) that sees dp_fault.
  task automatic do_run(input int fault_cycle);
    int done_at = 0;
    int nrun = 0;
    int bad = 0;
    @(negedge aclk);
    start = 1'b1;
    for (int c = 1; c <= 40 && done_at == 0; c++) begin
      @(negedge aclk);
      start = 1'b0;
      dp_fault = (c == fault_cycle);
      #1;
      if (dp_round_en === 1'b1) begin
        if (dp_round_index !== 5'(nrun * 3) || busy !== 1'b1 ||
            din_ready !== 1'b0 || dout_valid !== 1'b0) bad++;
        nrun++;
      end
      if (done === 1'b1) done_at = c;
    end
    dp_fault = 1'b0;
    checks++;
    if (done_at !== 9) begin
      errors++;
      $display("FAIL done_latency: got %0d cycles required 9", done_at);
    end
    checks++;
    if (nrun !== 8 || bad !== 0) begin
      errors++;
      $display("FAIL round_groups: got %0d groups (%0d bad) required 8 (0 bad)", nrun, bad);
    end
  endtask

  // Unload all 12 words; optionally hold dout_ready low 20 cycles after word stall_after.
  task automatic do_unload(input int stall_after, input bit exp_fault);
    int got = 0;
    int bad = 0;
    int stall_bad = 0;
    bit stalled = 1'b0;
    for (int c = 0; c < 80 && got < 12; c++) begin
      @(negedge aclk);
      if (got == stall_after && !stalled) begin
        stalled = 1'b1;
        dout_ready = 1'b0;
        for (int s = 0; s < 20; s++) begin
          #1;
          if (dout_valid !== 1'b1 || dout !== exp_dout(got, exp_fault) ||
              dp_shift_out !== 1'b0 || busy !== 1'b0) stall_bad++;
          @(negedge aclk);
        end
      end
      dout_ready = 1'b1;
      #1;
      if (dout_valid !== 1'b1 || dout !== exp_dout(got, exp_fault) ||
          dp_shift_out !== 1'b1 || fault_detected !== exp_fault) begin
        bad++;
        $display("  word %0d: dout=%h valid=%b fault=%b", got, dout, dout_valid, fault_detected);
      end
      got++;
    end
    @(negedge aclk);
    dout_ready = 1'b0;
    #1;
    checks++;
    if (got !== 12 || bad !== 0) begin
      errors++;
      $display("FAIL unload: got %0d words with %0d wrong, required 12 with 0 wrong", got, bad);
    end
    if (stalled) begin
      checks++;
      if (stall_bad !== 0) begin
        errors++;
        $display("FAIL stall: %0d stalled cycles wrong, required 0", stall_bad);
      end
    end
    checks++;
    if (dout_valid !== 1'b0 || din_ready !== 1'b1 || fault_detected !== exp_fault) begin
      errors++;
      $display("FAIL back_to_idle: valid=%b ready=%b fault=%b required 0 1 %b",
               dout_valid, din_ready, fault_detected, exp_fault);
    end
  endtask

  task automatic test_reset();
    logic [9:0] flags;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    #1;
    flags = {din_ready, dout_valid, busy, done, start_error, fault_detected,
             dp_load_word, dp_shift_out, dp_round_en, dp_clear};
    checks++;
    if (flags !== 10'b10_0000_0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 1000000000", flags);
    end
    checks++;
    if ({dout, dp_din, dp_round_index} !== 69'd0) begin
      errors++;
      $display("FAIL reset_buses: got dout=%h dp_din=%h idx=%0d required 0", dout, dp_din, dp_round_index);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    #1;
    checks++;
    if (din_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: ready=%b busy=%b required 1 0", din_ready, busy);
    end
  endtask

  task automatic test_basic_run();
    set_expected(32'h0000_0001);
    load_words(12, 32'h0000_0001);
    din_valid = 1'b1;
    din = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (din_ready !== 1'b0 || dp_load_word !== 1'b0) begin
      errors++;
      $display("FAIL word13: ready=%b load=%b required 0 0", din_ready, dp_load_word);
    end
    @(negedge aclk);
    din_valid = 1'b0;
    din = '0;
    do_run(0);
    do_unload(99, 1'b0);
  endtask

  task automatic test_start_error();
    set_expected(32'h0000_0101);
    load_words(11, 32'h0000_0101);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    #1;
    checks++;
    if (start_error !== 1'b1 || busy !== 1'b0 || dp_round_en !== 1'b0) begin
      errors++;
      $display("FAIL start_error: err=%b busy=%b round_en=%b required 1 0 0", start_error, busy, dp_round_en);
    end
    @(negedge aclk);
    #1;
    checks++;
    if (start_error !== 1'b0 || busy !== 1'b0 || din_ready !== 1'b1) begin
      errors++;
      $display("FAIL start_error_pulse: err=%b busy=%b ready=%b required 0 0 1", start_error, busy, din_ready);
    end
    load_words(1, 32'h0000_010C);
    do_run(0);
    do_unload(99, 1'b0);
  endtask

  task automatic test_fault();
    set_expected(32'h0000_0A00);
    load_words(12, 32'h0000_0A00);
    do_run(5);
    do_unload(99, 1'b1);
  endtask

  task automatic test_back_pressure();
    set_expected(32'h0000_0B00);
    load_words(12, 32'h0000_0B00);
    do_run(0);
    do_unload(4, 1'b0);
  endtask

  task automatic test_abort();
    int late_done = 0;
    load_words(12, 32'h0000_0C00);
    start = 1'b1;
    @(negedge aclk);
    start = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    abort = 1'b1;
    #1;
    checks++;
    if (dp_round_en !== 1'b1 || dp_round_index !== 5'd6) begin
      errors++;
      $display("FAIL abort_run3: round_en=%b idx=%0d required 1 6", dp_round_en, dp_round_index);
    end
    @(negedge aclk);
    abort = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || din_ready !== 1'b1 || dp_clear !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL abort_idle: busy=%b ready=%b clear=%b done=%b required 0 1 1 0",
               busy, din_ready, dp_clear, done);
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge aclk);
      #1;
      if (done !== 1'b0 || dp_clear !== 1'b0 || busy !== 1'b0) late_done++;
    end
    checks++;
    if (late_done !== 0) begin
      errors++;
      $display("FAIL abort_quiet: %0d cycles with done/clear/busy, required 0", late_done);
    end
    set_expected(32'h0000_0D00);
    load_words(12, 32'h0000_0D00);
    do_run(0);
    do_unload(99, 1'b0);
  endtask

  task automatic test_async_reset();
    logic [9:0] flags;
    set_expected(32'h0000_0E00);
    load_words(12, 32'h0000_0E00);
    do_run(2);
    dout_ready = 1'b1;
    repeat (3) @(negedge aclk);
    #1;
    checks++;
    if (dout_valid !== 1'b1 || fault_detected !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_unload: valid=%b fault=%b required 1 1", dout_valid, fault_detected);
    end
    aresetn = 1'b0;
    dout_ready = 1'b0;
    #1;
    flags = {din_ready, dout_valid, busy, done, start_error, fault_detected,
             dp_load_word, dp_shift_out, dp_round_en, dp_clear};
    checks++;
    if (flags !== 10'b10_0000_0000 || dout !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: flags=%b dout=%h required 1000000000 00000000", flags, dout);
    end
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    #1;
    checks++;
    if (din_ready !== 1'b1 || dout_valid !== 1'b0 || dp_clear !== 1'b0) begin
      errors++;
      $display("FAIL after_release: ready=%b valid=%b clear=%b required 1 0 0", din_ready, dout_valid, dp_clear);
    end
  endtask

  initial begin
    test_reset();
    test_basic_run();
    test_start_error();
    test_fault();
    test_back_pressure();
    test_abort();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
